// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract built from one 4-bit
// ripple-carry slice reused over WIDTH/4 cycles, least significant nibble
// first, with the inter-nibble carry held in a register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Operands transfer on start_valid & start_ready (ready only in
// IDLE); the result transfers on result_valid & result_ready (valid only in
// DONE). A producer may hold valid as long as it likes; nothing is accepted
// while ready is low, and the result stays bit-stable until it is taken.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / 4;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xa_q, xa_d;
  logic [WIDTH-1:0] yb_q, yb_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [KW+1:0]    bit_ofs;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice;

  // The single shared 4-bit slice, fed by the nibble selected with k.
  always_comb begin
    bit_ofs = {k_q, 2'b00};
    a_nib   = xa_q[bit_ofs +: 4];
    b_nib   = yb_q[bit_ofs +: 4];
    slice   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
  end

  // Next-state logic: accept operands, step one nibble per RUN cycle,
  // then hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    yb_d    = yb_q;
    c_d     = c_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          // Subtraction is x + ~y + 1, so invert y and force the carry in.
          xa_d    = x;
          yb_d    = sub ? ~y : y;
          c_d     = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[bit_ofs +: 4] = slice[3:0];
        c_d = slice[4];
        if (k_q == K_LAST) begin
          // slice[3] is the result MSB on the final nibble.
          cout_d  = slice[4];
          ovf_d   = (xa_q[WIDTH-1] == yb_q[WIDTH-1]) && (slice[3] != xa_q[WIDTH-1]);
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      xa_q    <= '0;
      yb_q    <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      yb_q    <= yb_d;
      c_q     <= c_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign ovf          = ovf_q;
  assign dbg_state    = state_q;

endmodule
